// File: rtl/fragment_stream_merge_pkg.sv
// Package for fragment_stream_merge: FSM state type, default widths and
// the location of the fragment-count field inside a header word.
package frag_merge_pkg;

   typedef enum logic [1:0] {
      ARB,
      HEADER,
      BODY
   } state_t;

   localparam int unsigned DATA_BITS_DEF = 32;
   localparam int unsigned LEN_BITS_DEF  = 16;

   // Fragment count occupies header bits [LEN_LSB +: LEN_BITS]
   localparam int unsigned LEN_LSB = 0;

endpackage

// File: rtl/fragment_stream_merge_if.sv
// Lane-parallel data/valid/ack stream bundle.
//   data : LANES words, lane i at [i*DATA_BITS +: DATA_BITS]
//   vld  : per-lane valid (driven by master)
//   ack  : per-lane ready (driven by slave); a word moves when vld & ack
interface fragment_stream_merge_if
   import frag_merge_pkg::*;
#(
   parameter int unsigned LANES     = 1,
   parameter int unsigned DATA_BITS = DATA_BITS_DEF
);
   logic [LANES*DATA_BITS-1:0] data;
   logic [LANES-1:0]           vld;
   logic [LANES-1:0]           ack;

   modport master (output data, output vld, input ack);
   modport slave  (input data, input vld, output ack);
endinterface

// File: rtl/fragment_stream_merge_rr_arbiter.sv
// Combinational rotating-priority pick: first asserted request at or above
// ptr, wrapping modulo NUM_IN.
//   req     : request vector
//   ptr     : index with highest priority
//   grant   : chosen index (0 when nothing requests)
//   any_req : at least one request asserted
module rr_arbiter #(
   parameter  int unsigned NUM_IN   = 4,
   localparam int unsigned SRC_BITS = $clog2(NUM_IN)
) (
   input  logic [NUM_IN-1:0]   req,
   input  logic [SRC_BITS-1:0] ptr,
   output logic [SRC_BITS-1:0] grant,
   output logic                any_req
);

   int unsigned idx;

   always_comb begin
      grant   = '0;
      any_req = 1'b0;
      idx     = 0;
      for (int unsigned k = 0; k < NUM_IN; k++) begin
         idx = 32'(ptr) + k;
         if (idx >= NUM_IN) idx = idx - NUM_IN;
         if (!any_req && req[SRC_BITS'(idx)]) begin
            any_req = 1'b1;
            grant   = SRC_BITS'(idx);
         end
      end
   end

endmodule

// File: rtl/fragment_stream_merge.sv
// Merges NUM_IN framed fragment streams (header with count N, then N payload
// words) into one stream. Whole packets are forwarded round-robin, never
// interleaved, through a one-entry output register slice.
//   clk, reset : clock, asynchronous active-high reset
//   in_s       : NUM_IN input lanes (slave side)
//   out_m      : merged single-lane output (master side)
//   cur_src    : index of the currently granted stream
//   pkt_cnt    : packets forwarded since reset, wraps at 2^32
module fragment_stream_merge
   import frag_merge_pkg::*;
#(
   parameter  int unsigned NUM_IN    = 4,
   parameter  int unsigned DATA_BITS = DATA_BITS_DEF,
   parameter  int unsigned LEN_BITS  = LEN_BITS_DEF,
   localparam int unsigned SRC_BITS  = $clog2(NUM_IN)
) (
   input  logic                 clk,
   input  logic                 reset,
   fragment_stream_merge_if.slave  in_s,
   fragment_stream_merge_if.master out_m,
   output logic [SRC_BITS-1:0]  cur_src,
   output logic [31:0]          pkt_cnt
);

   state_t                state, state_n;
   logic [SRC_BITS-1:0]   grant_n, ptr, ptr_n, next_ptr, arb_grant;
   logic [LEN_BITS-1:0]   remaining, rem_n;
   logic [31:0]           cnt_n;
   logic [DATA_BITS-1:0]  slot_data, slot_data_n;
   logic                  slot_vld, slot_vld_n;
   logic                  any_req, slot_free, xfer;
   logic [DATA_BITS-1:0]  words [NUM_IN];

   // Unpack lanes so the granted word can be selected by index
   for (genvar gi = 0; gi < NUM_IN; gi++) begin : g_word
      assign words[gi] = in_s.data[gi*DATA_BITS +: DATA_BITS];
   end

   rr_arbiter #(.NUM_IN(NUM_IN)) u_arb (
      .req     (in_s.vld),
      .ptr     (ptr),
      .grant   (arb_grant),
      .any_req (any_req)
   );

   assign slot_free = !slot_vld || out_m.ack[0];
   assign xfer      = (state != ARB) && in_s.vld[cur_src] && slot_free;
   assign next_ptr  = (cur_src == SRC_BITS'(NUM_IN - 1)) ? '0 : cur_src + SRC_BITS'(1);

   assign out_m.data = slot_data;
   assign out_m.vld  = slot_vld;

   // State and datapath registers
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= ARB;
         cur_src   <= '0;
         ptr       <= '0;
         remaining <= '0;
         pkt_cnt   <= '0;
         slot_data <= '0;
         slot_vld  <= 1'b0;
      end else begin
         state     <= state_n;
         cur_src   <= grant_n;
         ptr       <= ptr_n;
         remaining <= rem_n;
         pkt_cnt   <= cnt_n;
         slot_data <= slot_data_n;
         slot_vld  <= slot_vld_n;
      end
   end

   // Next state, slice load and ack (ack depends only on state/grant/out ack)
   always_comb begin
      state_n     = state;
      grant_n     = cur_src;
      ptr_n       = ptr;
      rem_n       = remaining;
      cnt_n       = pkt_cnt;
      slot_data_n = slot_data;
      slot_vld_n  = slot_vld && !out_m.ack[0];
      in_s.ack    = '0;

      case (state)
         ARB: begin
            if (any_req) begin
               grant_n = arb_grant;
               state_n = HEADER;
            end
         end
         HEADER: begin
            in_s.ack[cur_src] = slot_free;
            if (xfer) begin
               slot_data_n = words[cur_src];
               slot_vld_n  = 1'b1;
               rem_n       = words[cur_src][LEN_LSB +: LEN_BITS];
               if (words[cur_src][LEN_LSB +: LEN_BITS] == '0) begin
                  state_n = ARB;
                  ptr_n   = next_ptr;
                  cnt_n   = pkt_cnt + 32'd1;
               end else begin
                  state_n = BODY;
               end
            end
         end
         BODY: begin
            in_s.ack[cur_src] = slot_free;
            if (xfer) begin
               slot_data_n = words[cur_src];
               slot_vld_n  = 1'b1;
               rem_n       = remaining - LEN_BITS'(1);
               if (remaining == LEN_BITS'(1)) begin
                  state_n = ARB;
                  ptr_n   = next_ptr;
                  cnt_n   = pkt_cnt + 32'd1;
               end
            end
         end
         default: state_n = ARB;
      endcase
   end

endmodule

// File: doc/fragment_stream_merge.md
# fragment_stream_merge

Merges the four fragment streams produced by the rasterization2 page into one stream for the downstream z-culling page. Each input carries framed packets: a header word with a fragment count, then that many payload words. Packets are forwarded whole and never interleaved, and inputs are served round-robin. The block sits between the rasterization2 outputs and a single user-side input of the next leaf page, and uses the same 32-bit data/valid/ack handshake as the leaf user ports.

## Interface
- NUM_IN, 4, number of input streams (2..8)
- DATA_BITS, 32, word width
- LEN_BITS, 16, width of the fragment-count field, header bits [LEN_BITS-1:0]

- clk  input  1  clock, all logic on the rising edge
- reset  input  1  asynchronous, active-high reset
- in_data  input  NUM_IN*DATA_BITS  input words; stream i occupies bits [i*DATA_BITS +: DATA_BITS]
- in_vld  input  NUM_IN  per-stream valid
- in_ack  output  NUM_IN  per-stream ready; a word transfers when vld&ack
- out_data  output  DATA_BITS  merged stream word
- out_vld  output  1  merged stream valid
- out_ack  input  1  downstream ready
- cur_src  output  clog2(NUM_IN)  index of the stream currently granted
- pkt_cnt  output  32  packets forwarded since reset; wraps modulo 2^32

## Operation
- Output is a one-entry register slice. slot_free = !out_vld || out_ack. Loading the slot sets out_vld. Firing with out_ack and no load clears it.
- FSM states ARB, HEADER, BODY. Reset state is ARB.
- ARB:
  - Round-robin search starting at ptr for the first i with in_vld[i].
  - If found: grant=i, cur_src=i, go to HEADER.
  - In ARB, in_ack=0.
- HEADER:
  - in_ack[grant]=slot_free; all other in_ack bits are 0.
  - On transfer: copy the word unchanged into the slot and set remaining=header[LEN_BITS-1:0].
  - If N==0: go to ARB, set ptr=grant+1 mod NUM_IN, increment pkt_cnt.
  - Otherwise go to BODY.
- BODY:
  - Same ack rule as HEADER.
  - Each transfer copies the word and decrements remaining.
  - The transfer with remaining==1 goes to ARB, sets ptr=grant+1, and increments pkt_cnt.
- Header upper bits [DATA_BITS-1:LEN_BITS] pass through untouched. Payload words are never inspected.
- A deasserted in_vld[grant] mid-packet stalls the block. The grant is held and no other stream is served.
- in_ack is combinational from state, grant and out_ack. There is no combinational path from in_vld to in_ack.

## Timing
- Reset values: out_vld=0, out_data=0, in_ack=0, cur_src=0, pkt_cnt=0, ptr=0, remaining=0, state=ARB.
- Reset asserted mid-packet:
  - Any slot word is dropped and the partial packet is abandoned.
  - After release the block re-arbitrates from ptr=0. Upstream resynchronisation is the system's responsibility.
- Latency with out_ack held high:
  - in_vld seen in ARB at cycle t.
  - Header acked at t+1.
  - out_vld with header at t+2.
- Throughput:
  - Body words stream at 1 word/cycle.
  - One idle ARB cycle separates consecutive packets; packet rate is (N+2) cycles per packet.
- Backpressure: when out_vld=1 and out_ack=0, in_ack is 0 and out_data is held stable.
- Simultaneous events:
  - Slot fire and slot load in the same cycle: out_vld stays 1 and out_data takes the new word.
  - Several in_vld in ARB: grant goes to the first from ptr upward, modulo NUM_IN.
- remaining is LEN_BITS wide. N=2^LEN_BITS-1 is legal and must not overflow.

## Structure
- Package frag_merge_pkg holds:
  - the state enum {ARB, HEADER, BODY}
  - default DATA_BITS, LEN_BITS
  - the header length-field slice constants
- Sub-module rr_arbiter:
  - inputs NUM_IN request vector and ptr
  - outputs grant index and any_req
  - purely combinational priority rotate
- Top level holds the FSM, the remaining counter, the output slice and pkt_cnt.

## Test plan
- Single packet:
  - Stimulus: stream 2 sends header 0x0000_0003, then 0xA, 0xB, 0xC; out_ack=1.
  - Required: out stream header, A, B, C on consecutive cycles starting 2 cycles after in_vld; pkt_cnt=1; cur_src=2.
- Fairness:
  - Stimulus: all four streams continuously offer 1-word-body packets.
  - Required: grant order 0,1,2,3,0,…; every packet contiguous; pkt_cnt=8 after 8 packets.
- Zero-length packet:
  - Stimulus: stream 1 sends header 0x5A00_0000 (N=0).
  - Required: a single out word 0x5A00_0000; pkt_cnt increments; stream 1 is not acked again until its next packet is granted.
- Backpressure:
  - Stimulus: 4-word packet with out_ack toggling 1,0,0,1,….
  - Required: out_data stable while out_ack=0; no words lost or duplicated; in_ack=0 during stall cycles.
- Upstream bubble:
  - Stimulus: stream 0 drops in_vld for 3 cycles mid-body while stream 3 is valid.
  - Required: stream 3 never acked until stream 0's packet completes.
- Reset mid-packet:
  - Stimulus: assert reset during the BODY of a 10-word packet.
  - Required: out_vld=0, pkt_cnt=0 and in_ack=0 immediately (asynchronously); after release, the next header is forwarded normally.
